usb_in_ep_arbiter: RTL
======================

Name: usb_in_ep_arbiter

Overview:
- Shares one IN endpoint buffer interface between NUM_EP IN endpoint controllers (control EP, CDC data EP, CDC notify EP).
- Uses round-robin arbitration over each requester's req/grant handshake.
- Holds a grant for one whole packet, from the first put, through data_done, until the buffer reports the host ACK (or a timeout expires).
- Muxes the granted requester's data and control signals onto the shared buffer, and routes free/acked status back to that requester only.

Parameters:
NUM_EP, 4, number of IN endpoint requesters (2..8)
ACK_TIMEOUT, 1000, clk cycles to wait in WAIT_ACK before forcibly releasing the grant

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
ep_req  input  NUM_EP  per-requester access request
ep_grant  output  NUM_EP  one-hot grant, registered
ep_data_put  input  NUM_EP  per-requester byte strobe
ep_data  input  8*NUM_EP  per-requester byte; requester i occupies bits [8i+7:8i]
ep_data_done  input  NUM_EP  per-requester end-of-packet strobe
ep_stall  input  NUM_EP  per-requester stall request
ep_data_free  output  NUM_EP  buf_data_free gated by ep_grant[i]
ep_acked  output  NUM_EP  buf_acked gated by ep_grant[i], valid in WAIT_ACK only
buf_data_put  output  1  byte strobe to shared buffer
buf_data  output  8  byte to shared buffer
buf_data_done  output  1  end-of-packet to shared buffer
buf_stall  output  1  stall to shared buffer
buf_ep_num  output  3  index of granted requester, registered
buf_data_free  input  1  shared buffer can accept a byte
buf_acked  input  1  host ACKed the packet in the buffer

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, ep_grant=0, buf_ep_num=0, rr_ptr=0, timeout counter=0.
  - All buf_* outputs and ep_data_free/ep_acked are 0.
  - Reset overrides every other event in the same cycle, including mid-packet; no done is emitted.
- States: IDLE, GRANT, WAIT_ACK.
- IDLE:
  - If ep_req!=0, pick the first set bit at or after rr_ptr, wrapping modulo NUM_EP.
  - At the next edge: ep_grant=onehot(sel), buf_ep_num=sel, state=GRANT.
  - Request-to-grant latency is exactly 1 cycle. No grant is issued in IDLE otherwise.
- GRANT (g = granted index):
  - buf_data_put = ep_data_put[g] & buf_data_free.
  - buf_data = ep_data[g]; buf_data_done = ep_data_done[g]; buf_stall = ep_stall[g]. All combinational, zero latency.
  - Non-granted requesters' put/done/stall are ignored.
  - ep_data_done[g] → WAIT_ACK. A put and done in the same cycle forwards both.
  - ep_stall[g] (with or without done) → IDLE, release grant, rr_ptr=g+1.
  - ep_req[g] falls with no done/stall → abort: IDLE, release grant, rr_ptr=g+1, no done forwarded.
  - Priority when coincident: stall > done > req-drop.
- WAIT_ACK:
  - buf_data_put, buf_data_done and buf_stall are held 0.
  - ep_grant is held even if ep_req[g] falls.
  - The counter increments each cycle.
  - buf_acked → ep_acked[g]=1 that cycle; next edge: IDLE, grant released, rr_ptr=g+1, counter=0.
  - Counter reaches ACK_TIMEOUT-1 without an ack → IDLE, release, rr_ptr=g+1, counter=0, no ep_acked.
  - buf_acked on the timeout cycle counts as an ack.
- Grant and ack gating:
  - ep_grant clears on the edge that enters IDLE.
  - A new grant needs at least one IDLE cycle, so there are no back-to-back grants without an IDLE gap.
  - buf_acked outside WAIT_ACK is ignored.
- rr_ptr: width clog2(NUM_EP); g+1 wraps NUM_EP-1 → 0.
- Counter width: clog2(ACK_TIMEOUT)+1, no overflow.

Test Plan:
- Reset held low 3 cycles with ep_req=4'b1111 → ep_grant=0 and all buf_* =0. Release → ep_grant=4'b0001 exactly 1 cycle later.
- All four requesters continuously request, each sending 3 bytes + done followed by buf_acked 5 cycles later → grants in order 0,1,2,3,0. buf_ep_num matches each grant. Byte sequence on buf_data matches each requester in order.
- Requester 2 granted, sends 0xA5, 0x5A with buf_data_free toggling → buf_data_put only pulses when free=1. ep_data_free[2] mirrors buf_data_free; other ep_data_free bits stay 0.
- Requester 1 in GRANT drops ep_req without done → IDLE next cycle, buf_data_done never pulses, next grant goes to requester 2 when requests are pending.
- Requester 0 asserts put+done in the same cycle, then no buf_acked arrives → WAIT_ACK lasts 1000 cycles, grant released, ep_acked[0] never asserted.
- Requester 3 asserts stall and done together → buf_stall=1 for that cycle, IDLE next cycle (not WAIT_ACK), rr_ptr wraps to 0.

Source files
------------

// File: rtl/usb_in_ep_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_in_ep_arbiter: round-robin owner of the shared IN endpoint buffer.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module usb_in_ep_arbiter #(
   parameter int NUM_EP      = 4,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EP-1:0]     ep_req,
   output logic [NUM_EP-1:0]     ep_grant,
   input  logic [NUM_EP-1:0]     ep_data_put,
   input  logic [8*NUM_EP-1:0]   ep_data,
   input  logic [NUM_EP-1:0]     ep_data_done,
   input  logic [NUM_EP-1:0]     ep_stall,
   output logic [NUM_EP-1:0]     ep_data_free,
   output logic [NUM_EP-1:0]     ep_acked,
   output logic                  buf_data_put,
   output logic [7:0]            buf_data,
   output logic                  buf_data_done,
   output logic                  buf_stall,
   output logic [2:0]            buf_ep_num,
   input  logic                  buf_data_free,
   input  logic                  buf_acked
);

   localparam int c_PTR_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
   localparam int c_CNT_W = $clog2(ACK_TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_GRANT    = 2'd1,
      S_WAIT_ACK = 2'd2
   } state_t;

   state_t               r_state;
   logic [NUM_EP-1:0]    r_grant;
   logic [2:0]           r_ep_num;
   logic [c_PTR_W-1:0]   r_rr_ptr;
   logic [c_CNT_W-1:0]   r_cnt;

   logic [2*NUM_EP-1:0]  w_req_rot;
   logic [2:0]           w_sel;
   logic [NUM_EP-1:0]    w_sel_onehot;
   logic [c_PTR_W-1:0]   w_next_ptr;
   logic                 w_put;
   logic [7:0]           w_data;
   logic                 w_done;
   logic                 w_stall;
   logic                 w_req;
   logic                 w_in_grant;
   logic                 w_in_wait;
   logic                 w_timeout;

   // Rotate the doubled request vector so bit 0 is the requester at rr_ptr.
   assign w_req_rot = {ep_req, ep_req} >> r_rr_ptr;

   always_comb begin
      w_sel = '0;
      for (int k = NUM_EP - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            if (int'(r_rr_ptr) + k >= NUM_EP)
               w_sel = 3'(int'(r_rr_ptr) + k - NUM_EP);
            else
               w_sel = 3'(int'(r_rr_ptr) + k);
         end
      end
   end

   assign w_sel_onehot = {{(NUM_EP-1){1'b0}}, 1'b1} << w_sel;
   assign w_next_ptr   = (r_ep_num == 3'(NUM_EP - 1)) ? '0 : c_PTR_W'(r_ep_num + 3'd1);

   // Grant is one-hot, so an AND-OR mux selects the owner's lane.
   always_comb begin
      w_put   = 1'b0;
      w_data  = '0;
      w_done  = 1'b0;
      w_stall = 1'b0;
      w_req   = 1'b0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (r_grant[i]) begin
            w_put   = ep_data_put[i];
            w_data  = ep_data[8*i +: 8];
            w_done  = ep_data_done[i];
            w_stall = ep_stall[i];
            w_req   = ep_req[i];
         end
      end
   end

   assign w_in_grant = reset && (r_state == S_GRANT);
   assign w_in_wait  = reset && (r_state == S_WAIT_ACK);
   assign w_timeout  = (r_cnt == c_CNT_W'(ACK_TIMEOUT - 1));

   assign buf_data_put  = w_in_grant & w_put & buf_data_free;
   assign buf_data      = w_in_grant ? w_data : 8'd0;
   assign buf_data_done = w_in_grant & w_done;
   assign buf_stall     = w_in_grant & w_stall;
   assign buf_ep_num    = r_ep_num;
   assign ep_grant      = r_grant;

   generate
      for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_ep_status
         assign ep_data_free[gi] = reset & r_grant[gi] & buf_data_free;
         assign ep_acked[gi]     = w_in_wait & r_grant[gi] & buf_acked;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_ep_num <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|ep_req) begin
                  r_grant  <= w_sel_onehot;
                  r_ep_num <= w_sel;
                  r_state  <= S_GRANT;
               end
            end
            S_GRANT: begin
               // Stall beats done, and done beats a dropped request.
               if (w_stall || !w_req && !w_done) begin
                  r_grant  <= '0;
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= S_IDLE;
               end else if (w_done) begin
                  r_cnt    <= '0;
                  r_state  <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (buf_acked || w_timeout) begin
                  r_grant  <= '0;
                  r_rr_ptr <= w_next_ptr;
                  r_cnt    <= '0;
                  r_state  <= S_IDLE;
               end else begin
                  r_cnt    <= r_cnt + c_CNT_W'(1);
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
